// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes, FSM states
// and the start-op decode helper.
package md_defs;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Down-counter that models the fixed multiply/divide latency; flags the final busy cycle.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load on start, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: registers the result at the start edge, holds it for a
// fixed latency, then commits it to HI/LO; stalls D-stage HI/LO users while occupied.
module muldiv_sched
  import md_defs::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] E_MDop_i,
  input  logic [31:0]        E_RSdata_i,
  input  logic [31:0]        E_RTdata_i,
  input  logic               D_MDuse_i,
  output logic [31:0]        E_HI_o,
  output logic [31:0]        E_LO_o,
  output logic               E_MDbusy_o,
  output logic               D_MDstall_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic               cnt_load_s;
  logic [CNT_W-1:0]   cnt_load_val_s;
  logic               cnt_last_s;

  logic signed [63:0] smul_s;
  logic [63:0]        umul_s;
  logic               rt_zero_s;
  logic               sdiv_ovf_s;
  logic [31:0]        sdiv_den_s;
  logic [31:0]        udiv_den_s;
  logic signed [31:0] squot_s;
  logic signed [31:0] srem_s;
  logic [31:0]        uquot_s;
  logic [31:0]        urem_s;
  logic [63:0]        result_s;

  // Single-cycle arithmetic; the divisor is forced to 1 on zero or INT_MIN/-1 so the
  // simulated operator never traps (both cases are handled explicitly below or wrap correctly).
  always_comb begin
    smul_s     = $signed({{32{E_RSdata_i[31]}}, E_RSdata_i}) *
                 $signed({{32{E_RTdata_i[31]}}, E_RTdata_i});
    umul_s     = {32'd0, E_RSdata_i} * {32'd0, E_RTdata_i};
    rt_zero_s  = (E_RTdata_i == 32'd0);
    sdiv_ovf_s = (E_RSdata_i == 32'h8000_0000) && (E_RTdata_i == 32'hFFFF_FFFF);
    sdiv_den_s = (rt_zero_s || sdiv_ovf_s) ? 32'd1 : E_RTdata_i;
    udiv_den_s = rt_zero_s ? 32'd1 : E_RTdata_i;
    squot_s    = $signed(E_RSdata_i) / $signed(sdiv_den_s);
    srem_s     = $signed(E_RSdata_i) % $signed(sdiv_den_s);
    uquot_s    = E_RSdata_i / udiv_den_s;
    urem_s     = E_RSdata_i % udiv_den_s;
  end

  // Select the pending {HI,LO} for the op being started.
  always_comb begin
    result_s = {pend_hi_q, pend_lo_q};
    case (E_MDop_i)
      MD_MULT:  result_s = smul_s;
      MD_MULTU: result_s = umul_s;
      MD_DIV:   result_s = rt_zero_s ? {hi_q, lo_q} : {srem_s, squot_s};
      MD_DIVU:  result_s = rt_zero_s ? {hi_q, lo_q} : {urem_s, uquot_s};
      default:  result_s = {pend_hi_q, pend_lo_q};
    endcase
  end

  // FSM next state, HI/LO writes and latency counter load.
  always_comb begin
    state_d        = state_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    pend_hi_d      = pend_hi_q;
    pend_lo_d      = pend_lo_q;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    case (state_q)
      MD_IDLE: begin
        case (E_MDop_i)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            pend_hi_d      = result_s[63:32];
            pend_lo_d      = result_s[31:0];
            cnt_load_s     = 1'b1;
            cnt_load_val_s = md_is_div(E_MDop_i) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            state_d        = MD_BUSY;
          end
          MD_MTHI: hi_d = E_RSdata_i;
          MD_MTLO: lo_d = E_RSdata_i;
          default: state_d = MD_IDLE;
        endcase
      end
      MD_BUSY: begin
        if (cnt_last_s) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = MD_IDLE;
        end else begin
          state_d = MD_BUSY;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State and architectural/pending register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_load_val_s),
    .last_o     (cnt_last_s)
  );

  assign E_HI_o      = hi_q;
  assign E_LO_o      = lo_q;
  assign E_MDbusy_o  = (state_q == MD_BUSY);
  assign D_MDstall_o = D_MDuse_i & (E_MDbusy_o | md_is_start(E_MDop_i));

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: expected {HI,LO} and latency queued at issue,
// popped and compared when the unit goes idle again.
module tb_muldiv_sched;
  import md_defs::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [63:0] val;
    int          lat;
    int          stall;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [MD_OP_W-1:0] E_MDop_i;
  logic [31:0]        E_RSdata_i;
  logic [31:0]        E_RTdata_i;
  logic               D_MDuse_i;
  logic [31:0]        E_HI_o;
  logic [31:0]        E_LO_o;
  logic               E_MDbusy_o;
  logic               D_MDstall_o;

  exp_t        sb[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          n_chk;
  int          n_pass;

  muldiv_sched #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .E_MDop_i    (E_MDop_i),
    .E_RSdata_i  (E_RSdata_i),
    .E_RTdata_i  (E_RTdata_i),
    .D_MDuse_i   (D_MDuse_i),
    .E_HI_o      (E_HI_o),
    .E_LO_o      (E_LO_o),
    .E_MDbusy_o  (E_MDbusy_o),
    .D_MDstall_o (D_MDstall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline stall guarantees no HI/LO op reaches E while the unit is busy.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(E_MDbusy_o && (E_MDop_i >= 4'd1) && (E_MDop_i <= 4'd6)))
        else $error("op issued while unit busy");
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    longint            a;
    longint            b;
    longint            p;
    longint unsigned   up;
    logic [63:0]       q;
    logic [63:0]       r;
    case (op)
      MD_MULT: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        p = a * b;
        return p;
      end
      MD_MULTU: begin
        up = {32'd0, rs} * {32'd0, rt};
        return up;
      end
      MD_DIV: begin
        if (rt == 32'd0) return {model_hi, model_lo};
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (rt == 32'd0) return {model_hi, model_lo};
        q = {32'd0, rs} / {32'd0, rt};
        r = {32'd0, rs} % {32'd0, rt};
        return {r[31:0], q[31:0]};
      end
      MD_MTHI: return {rs, model_lo};
      MD_MTLO: return {model_hi, rs};
      default: return {model_hi, model_lo};
    endcase
  endfunction

  // Called just after a negative edge with the unit idle; returns in the first idle cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic use_d);
    exp_t e;
    int   busy_n;
    int   stall_n;
    logic done;
    e.val   = model(op, rs, rt);
    e.lat   = (op == MD_MULT || op == MD_MULTU) ? MUL_LAT :
              (op == MD_DIV  || op == MD_DIVU)  ? DIV_LAT : 0;
    e.stall = (use_d && e.lat > 0) ? e.lat + 1 : 0;
    sb.push_back(e);
    E_MDop_i   = op;
    E_RSdata_i = rs;
    E_RTdata_i = rt;
    D_MDuse_i  = use_d;
    #1;
    stall_n = D_MDstall_o ? 1 : 0;
    busy_n  = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      E_MDop_i = MD_NONE;
      #1;
      if (E_MDbusy_o) begin
        busy_n++;
        if (D_MDstall_o) stall_n++;
      end else begin
        done = 1'b1;
      end
    end
    e = sb.pop_front();
    check("busy_cycles", 64'(busy_n), 64'(e.lat));
    check("stall_cycles", 64'(stall_n), 64'(e.stall));
    check("stall_released", {63'd0, D_MDstall_o}, 64'd0);
    check("hilo", {E_HI_o, E_LO_o}, e.val);
    model_hi = e.val[63:32];
    model_lo = e.val[31:0];
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] rrs;
    logic [31:0] rrt;
    n_chk      = 0;
    n_pass     = 0;
    model_hi   = 32'd0;
    model_lo   = 32'd0;
    reset      = 1'b1;
    E_MDop_i   = MD_NONE;
    E_RSdata_i = 32'd0;
    E_RTdata_i = 32'd0;
    D_MDuse_i  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hi", {32'd0, E_HI_o}, 64'd0);
    check("rst_lo", {32'd0, E_LO_o}, 64'd0);
    check("rst_busy", {63'd0, E_MDbusy_o}, 64'd0);
    check("rst_stall", {63'd0, D_MDstall_o}, 64'd0);

    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_const", {E_HI_o, E_LO_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(MD_MULTU, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("multu_const", {E_HI_o, E_LO_o}, 64'h0000_0006_FFFF_FFEB);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_const", {E_HI_o, E_LO_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MD_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu_const", {E_HI_o, E_LO_o}, 64'h0000_0001_0000_0003);

    do_op(MD_MTHI, 32'h1234, 32'd0, 1'b0);
    do_op(MD_MTLO, 32'h5678, 32'd0, 1'b0);
    do_op(MD_DIV, 32'd99, 32'd0, 1'b0);
    check("div0_const", {E_HI_o, E_LO_o}, 64'h0000_1234_0000_5678);
    do_op(MD_DIVU, 32'd99, 32'd0, 1'b0);

    // mult followed by mflo in D: stall for the start cycle plus every busy cycle.
    do_op(MD_MULT, 32'd6, 32'd9, 1'b1);
    check("mflo_sees_lo", {32'd0, E_LO_o}, 64'd54);

    do_op(MD_MTHI, 32'hABCD, 32'd0, 1'b1);
    check("mthi_const", {32'd0, E_HI_o}, 64'h0000_ABCD);

    // Back-to-back mults with an unrelated instruction in D.
    do_op(MD_MULT, 32'd1000, 32'hFFFF_FFFF, 1'b0);
    do_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);

    do_op(4'd9, 32'h5555, 32'h3, 1'b1);
    do_op(4'd15, 32'h7777, 32'h1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(1, 6));
      rrs = $urandom;
      rrt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      do_op(rop, rrs, rrt, 1'($urandom_range(0, 1)));
    end

    // Reset while busy aborts the operation and clears HI/LO.
    do_op(MD_MTHI, 32'hDEAD, 32'd0, 1'b0);
    E_MDop_i   = MD_DIV;
    E_RSdata_i = 32'd100;
    E_RTdata_i = 32'd3;
    D_MDuse_i  = 1'b0;
    @(negedge clk);
    E_MDop_i = MD_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, E_MDbusy_o}, 64'd0);
    check("midrst_hilo", {E_HI_o, E_LO_o}, 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    do_op(MD_MULTU, 32'd12, 32'd12, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
